// File: rtl/perf_cnt_bank_pkg.sv
// Shared constants, CTRL field layout and helpers for the performance counter bank.
package perf_cnt_pckg;

    localparam int C_PERF_CNT_WDT      = 48;
    localparam int C_PERF_CNT_WORD_CNT = 3;

    // Byte offsets of the legacy counter slots within the bank
    localparam int C_PERF_OFS_RUN    = 0 * C_PERF_CNT_WORD_CNT * 4;
    localparam int C_PERF_OFS_COMP   = 1 * C_PERF_CNT_WORD_CNT * 4;
    localparam int C_PERF_OFS_C2H    = 2 * C_PERF_CNT_WORD_CNT * 4;
    localparam int C_PERF_OFS_H2C    = 3 * C_PERF_CNT_WORD_CNT * 4;
    localparam int C_PERF_OFS_CSTALL = 4 * C_PERF_CNT_WORD_CNT * 4;

    localparam int C_PERF_CTRL_EN_BIT     = 0;
    localparam int C_PERF_CTRL_CLR_BIT    = 1;
    localparam int C_PERF_CTRL_SNAP_BIT   = 2;
    localparam int C_PERF_CTRL_MODE_BIT   = 3;
    localparam int C_PERF_CTRL_SAT_BIT    = 4;
    localparam int C_PERF_CTRL_IRQEN_BIT  = 5;
    localparam int C_PERF_CTRL_OVF_BIT    = 8;

    localparam int C_PERF_SUB_CTRL = 0;
    localparam int C_PERF_SUB_LO   = 1;
    localparam int C_PERF_SUB_HI   = 2;

    typedef struct packed {
        logic ovf;
        logic ovf_irq_en;
        logic sat;
        logic mode;
        logic snap;
        logic clr;
        logic en;
    } perf_ctrl_t;

    function automatic perf_ctrl_t perf_ctrl_unpack(input logic [31:0] w);
        perf_ctrl_t c;
        c.en         = w[C_PERF_CTRL_EN_BIT];
        c.clr        = w[C_PERF_CTRL_CLR_BIT];
        c.snap       = w[C_PERF_CTRL_SNAP_BIT];
        c.mode       = w[C_PERF_CTRL_MODE_BIT];
        c.sat        = w[C_PERF_CTRL_SAT_BIT];
        c.ovf_irq_en = w[C_PERF_CTRL_IRQEN_BIT];
        c.ovf        = w[C_PERF_CTRL_OVF_BIT];
        return c;
    endfunction

    // clr and snap are strobes and always read back as 0
    function automatic logic [31:0] perf_ctrl_pack(input perf_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[C_PERF_CTRL_EN_BIT]    = c.en;
        w[C_PERF_CTRL_MODE_BIT]  = c.mode;
        w[C_PERF_CTRL_SAT_BIT]   = c.sat;
        w[C_PERF_CTRL_IRQEN_BIT] = c.ovf_irq_en;
        w[C_PERF_CTRL_OVF_BIT]   = c.ovf;
        return w;
    endfunction

endpackage

// File: rtl/perf_cnt_bank_if.sv
// Register bus between the regmap master and the counter bank.
interface perf_cnt_bank_if #(
    parameter int C_ADDR_WDT = 12,
    parameter int C_REG_WDT  = 32
);
    logic [C_ADDR_WDT-1:0] reg_addr_i;
    logic                  reg_wr_en_i;
    logic [C_REG_WDT-1:0]  reg_wr_data_i;
    logic                  reg_rd_en_i;
    logic [C_REG_WDT-1:0]  reg_rd_data_o;
    logic                  reg_rd_valid_o;

    modport master (
        output reg_addr_i, reg_wr_en_i, reg_wr_data_i, reg_rd_en_i,
        input  reg_rd_data_o, reg_rd_valid_o
    );

    modport slave (
        input  reg_addr_i, reg_wr_en_i, reg_wr_data_i, reg_rd_en_i,
        output reg_rd_data_o, reg_rd_valid_o
    );
endinterface

// File: rtl/perf_cnt_bank_unit.sv
// One performance counter: edge detect, wrap/saturate, sticky overflow and snapshot shadow.
module perf_cnt_unit
    import perf_cnt_pckg::*;
#(
    parameter int C_CNT_WDT = C_PERF_CNT_WDT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 event_i,
    input  logic                 freeze_i,
    input  logic                 ctrl_wr_i,
    input  perf_ctrl_t           wr_ctrl_i,
    output perf_ctrl_t           ctrl_o,
    output logic [C_CNT_WDT-1:0] shadow_o
);

    logic [C_CNT_WDT-1:0] cnt_q, cnt_d;
    logic [C_CNT_WDT-1:0] shadow_q, shadow_d;
    logic en_q, en_d, mode_q, mode_d, sat_q, sat_d;
    logic irq_en_q, irq_en_d, ovf_q, ovf_d, prev_q;
    logic hit, inc, clr, snap, all_ones;

    // Next-state: clear beats increment, snapshot takes the pre-update value, new overflow beats W1C
    always_comb begin
        hit      = mode_q ? (event_i & ~prev_q) : event_i;
        inc      = en_q & ~freeze_i & hit;
        clr      = ctrl_wr_i & wr_ctrl_i.clr;
        snap     = ctrl_wr_i & wr_ctrl_i.snap;
        all_ones = &cnt_q;
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (!all_ones) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!sat_q) begin
                cnt_d = '0;
            end
        end
        ovf_d    = (inc & all_ones & ~clr) | (ovf_q & ~(ctrl_wr_i & wr_ctrl_i.ovf));
        shadow_d = snap ? cnt_q : shadow_q;
        en_d     = ctrl_wr_i ? wr_ctrl_i.en         : en_q;
        mode_d   = ctrl_wr_i ? wr_ctrl_i.mode       : mode_q;
        sat_d    = ctrl_wr_i ? wr_ctrl_i.sat        : sat_q;
        irq_en_d = ctrl_wr_i ? wr_ctrl_i.ovf_irq_en : irq_en_q;
    end

    // Counter, shadow and control state; prev samples the event every cycle so enabling never sees a false edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            sat_q    <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            sat_q    <= sat_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            prev_q   <= event_i;
        end
    end

    // Readback view of the control fields
    always_comb begin
        ctrl_o            = '0;
        ctrl_o.en         = en_q;
        ctrl_o.mode       = mode_q;
        ctrl_o.sat        = sat_q;
        ctrl_o.ovf_irq_en = irq_en_q;
        ctrl_o.ovf        = ovf_q;
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/perf_cnt_bank.sv
// Bank of performance counters: register decode, read mux and overflow interrupt.
module perf_cnt_bank
    import perf_cnt_pckg::*;
#(
    parameter int C_CNT_NUM  = 5,
    parameter int C_CNT_WDT  = C_PERF_CNT_WDT,
    parameter int C_REG_WDT  = 32,
    parameter int C_WORD_CNT = C_PERF_CNT_WORD_CNT,
    parameter int C_ADDR_WDT = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [C_CNT_NUM-1:0] event_i,
    input  logic                 freeze_i,
    perf_cnt_bank_if.slave       reg_bus,
    output logic                 ovf_irq_o
);

    logic [C_ADDR_WDT-1:0] word, cnt_idx, sub;
    perf_ctrl_t            wr_ctrl;
    perf_ctrl_t            ctrl [C_CNT_NUM];
    logic [C_CNT_WDT-1:0]  shadow [C_CNT_NUM];
    logic [C_CNT_NUM-1:0]  ctrl_wr, irq_vec;
    logic [C_REG_WDT-1:0]  rd_word, rd_data_q, rd_data_d;
    logic                  rd_valid_q, irq_q;

    assign word    = reg_bus.reg_addr_i >> 2;
    assign cnt_idx = word / C_ADDR_WDT'(C_WORD_CNT);
    assign sub     = word % C_ADDR_WDT'(C_WORD_CNT);
    assign wr_ctrl = perf_ctrl_unpack(32'(reg_bus.reg_wr_data_i));

    for (genvar i = 0; i < C_CNT_NUM; i++) begin : g_unit
        assign ctrl_wr[i] = reg_bus.reg_wr_en_i && (sub == C_ADDR_WDT'(C_PERF_SUB_CTRL))
                            && (cnt_idx == C_ADDR_WDT'(i));
        assign irq_vec[i] = ctrl[i].ovf & ctrl[i].ovf_irq_en;

        perf_cnt_unit #(.C_CNT_WDT(C_CNT_WDT)) u_unit (
            .clk       (clk),
            .rst_n     (rst_n),
            .event_i   (event_i[i]),
            .freeze_i  (freeze_i),
            .ctrl_wr_i (ctrl_wr[i]),
            .wr_ctrl_i (wr_ctrl),
            .ctrl_o    (ctrl[i]),
            .shadow_o  (shadow[i])
        );
    end

    // Read mux; addresses past the last counter decode to zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_CNT_NUM; i++) begin
            if (cnt_idx == C_ADDR_WDT'(i)) begin
                if (sub == C_ADDR_WDT'(C_PERF_SUB_CTRL)) begin
                    rd_word = C_REG_WDT'(perf_ctrl_pack(ctrl[i]));
                end else if (sub == C_ADDR_WDT'(C_PERF_SUB_LO)) begin
                    rd_word = C_REG_WDT'(shadow[i]);
                end else begin
                    rd_word = C_REG_WDT'(shadow[i] >> 32);
                end
            end
        end
        rd_data_d = reg_bus.reg_rd_en_i ? rd_word : rd_data_q;
    end

    // Registered read response, held until the next read, and registered interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= reg_bus.reg_rd_en_i;
            irq_q      <= |irq_vec;
        end
    end

    assign reg_bus.reg_rd_data_o  = rd_data_q;
    assign reg_bus.reg_rd_valid_o = rd_valid_q;
    assign ovf_irq_o              = irq_q;

endmodule

// File: tb/tb_perf_cnt_bank.sv
module tb_perf_cnt_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ev;
    logic       freeze;
    logic       irq;
    int         errors = 0;
    int         checks = 0;

    perf_cnt_bank_if #(.C_ADDR_WDT(12), .C_REG_WDT(32)) bus ();

    perf_cnt_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .event_i   (ev),
        .freeze_i  (freeze),
        .reg_bus   (bus),
        .ovf_irq_o (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] waddr(input int k, input int sub);
        return 12'((k * 3 + sub) * 4);
    endfunction

    // All tasks start and end on a falling edge
    task automatic reg_write(input int k, input int sub, input logic [31:0] d);
        bus.reg_addr_i    = waddr(k, sub);
        bus.reg_wr_data_i = d;
        bus.reg_wr_en_i   = 1'b1;
        @(negedge clk);
        bus.reg_wr_en_i   = 1'b0;
    endtask

    task automatic reg_read(input int k, input int sub, output logic [31:0] d, output logic v);
        bus.reg_addr_i  = waddr(k, sub);
        bus.reg_rd_en_i = 1'b1;
        @(negedge clk);
        bus.reg_rd_en_i = 1'b0;
        d = bus.reg_rd_data_o;
        v = bus.reg_rd_valid_o;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        rst_n = 1'b0;
        ev = '0; freeze = 1'b0;
        bus.reg_addr_i = '0; bus.reg_wr_en_i = 1'b0; bus.reg_wr_data_i = '0; bus.reg_rd_en_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.reg_rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", bus.reg_rd_data_o); end
        checks++; if (bus.reg_rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.reg_rd_valid_o); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst_n = 1'b1;
        @(negedge clk);
        reg_read(0, 0, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_ctrl0 got=%h/%b exp=0/1", d, v); end
        reg_read(4, 1, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_lo4 got=%h exp=0", d); end
    endtask

    task automatic test_level();
        logic [31:0] d;
        logic        v;
        reg_write(0, 0, 32'h01);
        ev[0] = 1'b1;
        repeat (10) @(negedge clk);
        ev[0] = 1'b0;
        reg_write(0, 0, 32'h05);
        reg_read(0, 1, d, v);
        checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL level_lo got=%h exp=0000000a", d); end
        reg_read(0, 2, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL level_hi got=%h exp=0", d); end
        reg_read(0, 0, d, v);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL level_ctrl got=%h exp=01", d); end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        logic        v;
        logic [9:0]  pat;
        pat = 10'b1100110011;
        reg_write(1, 0, 32'h09);
        for (int i = 0; i < 10; i++) begin
            ev[1] = pat[9 - i];
            @(negedge clk);
        end
        ev[1] = 1'b0;
        reg_write(1, 0, 32'h0D);
        reg_read(1, 1, d, v);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL edge_count got=%h exp=3", d); end
        // event already high when edge mode is enabled: no count
        ev[2] = 1'b1;
        repeat (2) @(negedge clk);
        reg_write(2, 0, 32'h09);
        repeat (5) @(negedge clk);
        reg_write(2, 0, 32'h0D);
        ev[2] = 1'b0;
        reg_read(2, 1, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_no_spurious got=%h exp=0", d); end
    endtask

    task automatic test_wrap_sat();
        logic [31:0] d;
        logic        v;
        reg_write(0, 0, 32'h22);
        force dut.g_unit[0].u_unit.cnt_q = 48'hFFFF_FFFF_FFFF;
        #1 release dut.g_unit[0].u_unit.cnt_q;
        @(negedge clk);
        reg_write(0, 0, 32'h21);
        ev[0] = 1'b1;
        @(negedge clk);
        ev[0] = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_early got=%b exp=0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wrap_irq got=%b exp=1", irq); end
        reg_write(0, 0, 32'h25);
        reg_read(0, 1, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_lo got=%h exp=0", d); end
        reg_read(0, 2, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi got=%h exp=0", d); end
        reg_read(0, 0, d, v);
        checks++; if (d !== 32'h121) begin errors++; $display("FAIL wrap_ctrl got=%h exp=121", d); end
        reg_write(0, 0, 32'h121);
        reg_read(0, 0, d, v);
        checks++; if (d !== 32'h21) begin errors++; $display("FAIL w1c_ctrl got=%h exp=21", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        // saturate
        reg_write(0, 0, 32'h10);
        force dut.g_unit[0].u_unit.cnt_q = 48'hFFFF_FFFF_FFFF;
        #1 release dut.g_unit[0].u_unit.cnt_q;
        @(negedge clk);
        reg_write(0, 0, 32'h11);
        ev[0] = 1'b1;
        repeat (2) @(negedge clk);
        ev[0] = 1'b0;
        reg_write(0, 0, 32'h15);
        reg_read(0, 1, d, v);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_lo got=%h exp=ffffffff", d); end
        reg_read(0, 2, d, v);
        checks++; if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL sat_hi got=%h exp=0000ffff", d); end
        reg_read(0, 0, d, v);
        checks++; if (d !== 32'h111) begin errors++; $display("FAIL sat_ctrl got=%h exp=111", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sat_irq_masked got=%b exp=0", irq); end
        reg_write(0, 0, 32'h110);
        reg_read(0, 0, d, v);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL sat_w1c got=%h exp=10", d); end
    endtask

    task automatic test_coherence();
        logic [31:0] d;
        logic        v;
        force dut.g_unit[3].u_unit.cnt_q = 48'h0000_FFFF_FFFF;
        #1 release dut.g_unit[3].u_unit.cnt_q;
        @(negedge clk);
        reg_write(3, 0, 32'h05);
        ev[3] = 1'b1;
        repeat (100) @(negedge clk);
        ev[3] = 1'b0;
        reg_read(3, 1, d, v);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL coh_lo got=%h exp=ffffffff", d); end
        reg_read(3, 2, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL coh_hi got=%h exp=0", d); end
        reg_write(3, 0, 32'h05);
        reg_read(3, 2, d, v);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL coh_hi2 got=%h exp=1", d); end
        reg_read(3, 1, d, v);
        checks++; if (d !== 32'h63) begin errors++; $display("FAIL coh_lo2 got=%h exp=63", d); end
    endtask

    task automatic test_snap_clr_freeze();
        logic [31:0] d;
        logic        v;
        reg_write(4, 0, 32'h01);
        ev[4] = 1'b1;
        repeat (7) @(negedge clk);
        reg_write(4, 0, 32'h07);
        ev[4] = 1'b0;
        reg_read(4, 1, d, v);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL snapclr_shadow got=%h exp=7", d); end
        reg_write(4, 0, 32'h05);
        reg_read(4, 1, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL snapclr_cnt got=%h exp=0", d); end
        ev[4] = 1'b1;
        repeat (5) @(negedge clk);
        freeze = 1'b1;
        repeat (18) @(negedge clk);
        reg_write(4, 0, 32'h05);
        @(negedge clk);
        freeze = 1'b0;
        ev[4] = 1'b0;
        reg_read(4, 1, d, v);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL freeze_hold got=%h exp=5", d); end
        freeze = 1'b1;
        reg_write(4, 0, 32'h03);
        reg_write(4, 0, 32'h05);
        freeze = 1'b0;
        reg_read(4, 1, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL freeze_clr got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        // read and write of the same CTRL in one cycle: read sees the old value
        bus.reg_addr_i    = waddr(2, 0);
        bus.reg_wr_data_i = 32'h01;
        bus.reg_wr_en_i   = 1'b1;
        bus.reg_rd_en_i   = 1'b1;
        @(negedge clk);
        bus.reg_wr_en_i   = 1'b0;
        bus.reg_rd_en_i   = 1'b0;
        checks++; if (bus.reg_rd_data_o !== 32'h09) begin errors++; $display("FAIL rw_same got=%h exp=09", bus.reg_rd_data_o); end
        reg_read(2, 0, d, v);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL rw_after got=%h exp=01", d); end
        // consecutive reads
        bus.reg_addr_i  = waddr(1, 0);
        bus.reg_rd_en_i = 1'b1;
        @(negedge clk);
        bus.reg_addr_i  = waddr(1, 1);
        checks++; if (bus.reg_rd_data_o !== 32'h09 || bus.reg_rd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h/%b exp=09/1", bus.reg_rd_data_o, bus.reg_rd_valid_o); end
        @(negedge clk);
        bus.reg_rd_en_i = 1'b0;
        checks++; if (bus.reg_rd_data_o !== 32'h3 || bus.reg_rd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_second got=%h/%b exp=3/1", bus.reg_rd_data_o, bus.reg_rd_valid_o); end
        repeat (3) @(negedge clk);
        checks++; if (bus.reg_rd_data_o !== 32'h3 || bus.reg_rd_valid_o !== 1'b0) begin errors++; $display("FAIL rd_hold got=%h/%b exp=3/0", bus.reg_rd_data_o, bus.reg_rd_valid_o); end
        // out-of-range counter index
        reg_read(5, 0, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL oor_ctrl got=%h/%b exp=0/1", d, v); end
        reg_read(1, 1, d, v);
        reg_read(5, 1, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL oor_lo got=%h/%b exp=0/1", d, v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        reg_write(1, 0, 32'h02);
        force dut.g_unit[1].u_unit.cnt_q = 48'hFFFF_FFFF_FFFF;
        #1 release dut.g_unit[1].u_unit.cnt_q;
        @(negedge clk);
        reg_write(1, 0, 32'h21);
        reg_write(3, 0, 32'h01);
        ev[1] = 1'b1; ev[3] = 1'b1;
        @(negedge clk);
        ev[1] = 1'b0;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got=%b exp=1", irq); end
        bus.reg_addr_i  = waddr(1, 0);
        bus.reg_rd_en_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        @(negedge clk);
        bus.reg_rd_en_i = 1'b0;
        checks++; if (bus.reg_rd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid_drop got=%b exp=0", bus.reg_rd_valid_o); end
        rst_n = 1'b1;
        @(negedge clk);
        reg_read(1, 0, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl1 got=%h exp=0", d); end
        reg_write(3, 0, 32'h04);
        reg_read(3, 1, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_lo3 got=%h exp=0", d); end
        reg_read(3, 2, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_hi3 got=%h exp=0", d); end
        ev[3] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_wrap_sat();
        test_coherence();
        test_snap_clr_freeze();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perf_cnt_bank.md
Name: perf_cnt_bank

Overview:
- Parametrised bank of C_CNT_NUM hardware performance counters, each C_CNT_WDT bits wide. Successor to the fixed five-counter, 48-bit, 3-word layout (run, comp, stream C2H, stream H2C, cache stall).
- Adds per-counter mode control: level/edge counting, wrap/saturate, sticky overflow, atomic snapshot, and a global freeze.
- Sits behind the regmap slave; event inputs come from the accelerator pipeline, stream DMA interfaces and cache.

Parameters:
- C_CNT_NUM, 5, number of counters (one event input each).
- C_CNT_WDT, 48, counter width; range 33..64.
- C_REG_WDT, 32, register data width.
- C_WORD_CNT, 3, register words per counter (ctrl, lower, upper); fixed at 3.
- C_ADDR_WDT, 12, byte address width, relative to the bank base.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- event_i  in  C_CNT_NUM  per-counter event qualifier.
- freeze_i  in  1  global freeze; no counter changes value while high.
- reg_addr_i  in  C_ADDR_WDT  byte address, word aligned.
- reg_wr_en_i  in  1  write strobe, single cycle.
- reg_wr_data_i  in  C_REG_WDT  write data.
- reg_rd_en_i  in  1  read strobe, single cycle.
- reg_rd_data_o  out  C_REG_WDT  read data.
- reg_rd_valid_o  out  1  read data valid.
- ovf_irq_o  out  1  OR of all (ovf AND ovf_irq_en) bits.

Behaviour:
- Reset: every counter, shadow, ctrl field, ovf bit and edge-history flop = 0. reg_rd_data_o = 0, reg_rd_valid_o = 0, ovf_irq_o = 0.
- Address map: word = reg_addr_i/4; counter k = word / 3; sub = word mod 3.
  - sub 0: CTRL.
  - sub 1: shadow[31:0].
  - sub 2: shadow[C_CNT_WDT-1:32], zero-extended.
  - k >= C_CNT_NUM: reads return 0; writes are ignored.
- CTRL bits:
  - bit0 en (RW).
  - bit1 clr (write 1, self-clearing, reads 0).
  - bit2 snap (write 1, self-clearing, reads 0).
  - bit3 mode: 0 = level (count every cycle event high), 1 = edge (count 0->1 transitions).
  - bit4 sat: 0 = wrap, 1 = saturate.
  - bit5 ovf_irq_en (RW).
  - bit8 ovf: sticky, read-only, cleared by writing 1 (W1C).
  - Other bits read 0.
- Increment condition, cycle t: en & ~freeze_i & hit.
  - hit = event_i[k] in level mode.
  - hit = event_i[k] & ~prev[k] in edge mode.
  - prev[k] samples event_i[k] every cycle regardless of en/freeze, so enabling never produces a spurious edge.
- Counter visible +1 on cycle t+1.
- At all-ones with an increment:
  - wrap mode -> 0, ovf set.
  - sat mode -> holds all-ones, ovf set.
- clr write: counter <= 0 on the next edge; clr beats a same-cycle increment.
- snap write: shadow <= counter value before this cycle's update.
  - snap+clr in one write: shadow gets the pre-clear value, counter = 0.
  - Lower and upper reads always return the same snapshot, so 48-bit reads are coherent.
- ovf W1C in the same cycle as a new overflow: set wins (ovf stays 1).
- Read: reg_rd_valid_o pulses 1 cycle after reg_rd_en_i with reg_rd_data_o.
  - reg_rd_data_o holds its value until the next read.
  - Back-to-back reads are supported, one per cycle.
- Read and write in the same cycle to the same CTRL: read returns the pre-write value.
- freeze_i: counters hold. Snapshot, clear and register access still work; clr while frozen still zeroes the counter.
- ovf_irq_o is registered and rises 1 cycle after ovf sets.
- rst_n asserted mid-operation: immediate return to reset values. A pending read's valid is dropped.

Decomposition:
- perf_cnt_pckg holds:
  - C_PERF_CNT_WDT, C_PERF_CNT_WORD_CNT.
  - Counter offset constants.
  - CTRL bit-index constants: C_PERF_CTRL_EN_BIT .. C_PERF_CTRL_OVF_BIT.
  - Sub-word offsets.
  - typedef perf_ctrl_t (packed struct of the CTRL fields).
- One sub-module, perf_cnt_unit: a single counter with edge detect, wrap/sat logic, ovf and shadow. It is instantiated C_CNT_NUM times by a generate loop.
- Top level does address decode, the read mux and the IRQ OR.

Test Plan:
- Level count: CTRL0 = 0x01, event_i[0] high 10 cycles, snap, read words 1 and 2 -> 0x0000000A, 0x00000000.
- Edge mode: CTRL1 = 0x09, event_i[1] pattern 1100110011 (one bit per cycle, starting low before) -> snapshot 3. The enable write itself produces no spurious count.
- Wrap/sat at C_CNT_WDT = 48: force counter 0xFFFFFFFFFFFF, one event.
  - Wrap -> 0, ovf = 1, ovf_irq_o = 1 one cycle later when ovf_irq_en is set.
  - Sat -> stays 0xFFFFFFFFFFFF.
  - W1C of bit8 -> ovf = 0.
- Snapshot coherence: counter at 0x00000000FFFFFFFF, snap, let it run 100 events, read low/high -> 0xFFFFFFFF / 0x00000000.
- Simultaneous events: snap+clr with event high -> shadow = old value, counter = 0 next cycle. freeze_i high 20 cycles with events -> count unchanged.
- Out-of-range address k = C_CNT_NUM read -> 0, valid pulses. rst_n low mid-count -> all reads 0 afterwards.
